// File: rtl/wb_checker.sv
// Writeback stream checker: compares the core's register writebacks
// against a preloaded table of expected (rd, data) entries.
module wb_checker #(
  parameter int XLEN      = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 64,
  parameter int STRICT    = 1,
  parameter int IGNORE_X0 = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [REG_W-1:0]         ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic [$clog2(DEPTH):0]   num_exp,
  input  logic                     start,
  input  logic                     wb_e,
  input  logic [REG_W-1:0]         wb_a,
  input  logic [XLEN-1:0]          wb_d,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [REG_W-1:0]         fail_rd,
  output logic [XLEN-1:0]          fail_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   MAX_N = (IW+1)'(DEPTH);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW:0]       cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              tmo_q, tmo_d;
  logic [IW-1:0]     fidx_q, fidx_d;
  logic [REG_W-1:0]  frd_q, frd_d;
  logic [XLEN-1:0]   fdat_q, fdat_d;

  logic [REG_W-1:0]  tbl_rd   [DEPTH];
  logic [XLEN-1:0]   tbl_data [DEPTH];

  logic [REG_W-1:0]  ent_rd;
  logic [XLEN-1:0]   ent_data;
  logic [IW:0]       num_c;
  logic              qual, rd_eq, hit, bad, last;

  // Table is deliberately left out of reset so it survives an aborted run
  always_ff @(posedge clk) begin
    if (ld_en && state_q != S_RUN) begin
      tbl_rd[ld_idx]   <= ld_rd;
      tbl_data[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    ent_rd   = tbl_rd[ptr_q];
    ent_data = tbl_data[ptr_q];
    num_c    = (num_exp > MAX_N) ? MAX_N : num_exp;
    qual     = wb_e && !((IGNORE_X0 != 0) && (wb_a == '0));
    rd_eq    = (wb_a == ent_rd);
    hit      = qual && rd_eq && (wb_d == ent_data);
    bad      = qual && !hit && ((STRICT != 0) || rd_eq);
    last     = ({1'b0, ptr_q} == (cnt_q - (IW+1)'(1)));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    tmo_d   = tmo_q;
    fidx_d  = fidx_q;
    frd_d   = frd_q;
    fdat_d  = fdat_q;
    unique case (state_q)
      S_RUN: begin
        if (hit) begin
          tmr_d = '0;
          if (last) state_d = S_PASS;
          else      ptr_d   = ptr_q + IW'(1);
        end else if (bad) begin
          state_d = S_FAIL;
          fidx_d  = ptr_q;
          frd_d   = wb_a;
          fdat_d  = wb_d;
        end else if (tmr_q == T_MAX) begin
          state_d = S_FAIL;
          tmo_d   = 1'b1;
          fidx_d  = ptr_q;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          ptr_d   = '0;
          tmr_d   = '0;
          tmo_d   = 1'b0;
          fidx_d  = '0;
          frd_d   = '0;
          fdat_d  = '0;
          cnt_d   = num_c;
          state_d = (num_c == '0) ? S_PASS : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      tmo_q   <= 1'b0;
      fidx_q  <= '0;
      frd_q   <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      tmo_q   <= tmo_d;
      fidx_q  <= fidx_d;
      frd_q   <= frd_d;
      fdat_q  <= fdat_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass      = (state_q == S_PASS);
  assign timeout   = tmo_q;
  assign fail_idx  = fidx_q;
  assign fail_rd   = frd_q;
  assign fail_data = fdat_q;

endmodule

// File: tb/tb_wb_checker.sv
// Directed bench for wb_checker: a STRICT=1 and a STRICT=0 instance
// share the same table load and writeback stimulus.
module tb_wb_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  num_exp = '0;
  logic        start = 1'b0;
  logic        wb_e = 1'b0;
  logic [4:0]  wb_a = '0;
  logic [31:0] wb_d = '0;

  logic        busy_s, done_s, pass_s, tmo_s;
  logic [3:0]  fidx_s;
  logic [4:0]  frd_s;
  logic [31:0] fdat_s;
  logic        busy_l, done_l, pass_l, tmo_l;
  logic [3:0]  fidx_l;
  logic [4:0]  frd_l;
  logic [31:0] fdat_l;

  logic [3:0] st_s, st_l;
  assign st_s = {busy_s, done_s, pass_s, tmo_s};
  assign st_l = {busy_l, done_l, pass_l, tmo_l};

  int tests = 0;
  int fails = 0;

  logic [4:0]  e_rd [4] = '{5'd1, 5'd2, 5'd7, 5'd3};
  logic [31:0] e_d  [4] = '{32'hDEADBEEF, 32'h12345678,
                            32'h00000004, 32'hFEDCBA98};

  always #5 clk = ~clk;

  wb_checker #(.STRICT(1)) u_s (
    .clk(clk), .reset_n(reset_n),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_rd(ld_rd), .ld_data(ld_data),
    .num_exp(num_exp), .start(start),
    .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .busy(busy_s), .done(done_s), .pass(pass_s), .timeout(tmo_s),
    .fail_idx(fidx_s), .fail_rd(frd_s), .fail_data(fdat_s)
  );

  wb_checker #(.STRICT(0)) u_l (
    .clk(clk), .reset_n(reset_n),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_rd(ld_rd), .ld_data(ld_data),
    .num_exp(num_exp), .start(start),
    .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .busy(busy_l), .done(done_l), .pass(pass_l), .timeout(tmo_l),
    .fail_idx(fidx_l), .fail_rd(frd_l), .fail_data(fdat_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [4:0] a, input logic [31:0] d);
    wb_e = 1'b1;
    wb_a = a;
    wb_d = d;
    step();
    wb_e = 1'b0;
  endtask

  task automatic run(input logic [4:0] n);
    num_exp = n;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic load_std();
    for (int i = 0; i < 4; i++) begin
      ld_en   = 1'b1;
      ld_idx  = 4'(i);
      ld_rd   = e_rd[i];
      ld_data = e_d[i];
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (st_s !== 4'b0000 || st_l !== 4'b0000) begin
      fails++;
      $display("FAIL reset_status: got %b/%b exp 0000", st_s, st_l);
    end
    tests++;
    if ({fidx_s, frd_s, fdat_s} !== 41'd0) begin
      fails++;
      $display("FAIL reset_fail_regs: got %h/%h/%h exp 0",
               fidx_s, frd_s, fdat_s);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_pass();
    load_std();
    run(5'd4);
    tests++;
    if (st_s !== 4'b1000) begin
      fails++;
      $display("FAIL pass_busy: got %b exp 1000", st_s);
    end
    for (int i = 0; i < 3; i++) ev(e_rd[i], e_d[i]);
    tests++;
    if (st_s !== 4'b1000) begin
      fails++;
      $display("FAIL pass_early_done: got %b exp 1000", st_s);
    end
    ev(e_rd[3], e_d[3]);
    tests++;
    if (st_s !== 4'b0110 || st_l !== 4'b0110) begin
      fails++;
      $display("FAIL pass_done: got %b/%b exp 0110", st_s, st_l);
    end
    ev(5'd9, 32'h1);
    step();
    tests++;
    if (st_s !== 4'b0110 || frd_s !== 5'd0) begin
      fails++;
      $display("FAIL pass_hold: got %b rd %h exp 0110 rd 0", st_s, frd_s);
    end
  endtask

  task automatic test_mismatch();
    run(5'd4);
    ev(e_rd[0], e_d[0]);
    ev(e_rd[1], e_d[1]);
    ev(5'd7, 32'h00000005);
    tests++;
    if (st_s !== 4'b0100 || st_l !== 4'b0100) begin
      fails++;
      $display("FAIL mismatch_status: got %b/%b exp 0100", st_s, st_l);
    end
    tests++;
    if (fidx_s !== 4'd2 || frd_s !== 5'd7 || fdat_s !== 32'h5) begin
      fails++;
      $display("FAIL mismatch_info: got %h/%h/%h exp 2/07/00000005",
               fidx_s, frd_s, fdat_s);
    end
    tests++;
    if (fidx_l !== 4'd2 || frd_l !== 5'd7 || fdat_l !== 32'h5) begin
      fails++;
      $display("FAIL mismatch_info_loose: got %h/%h/%h exp 2/07/00000005",
               fidx_l, frd_l, fdat_l);
    end
  endtask

  task automatic test_timeout();
    run(5'd4);
    tests++;
    if (st_s !== 4'b1000 || frd_s !== 5'd0 || fdat_s !== 32'd0) begin
      fails++;
      $display("FAIL restart_clear: got %b %h %h exp 1000 0 0",
               st_s, frd_s, fdat_s);
    end
    ev(e_rd[0], e_d[0]);
    ev(e_rd[1], e_d[1]);
    repeat (63) step();
    tests++;
    if (st_s !== 4'b1000) begin
      fails++;
      $display("FAIL timeout_early: got %b exp 1000", st_s);
    end
    step();
    tests++;
    if (st_s !== 4'b0101 || st_l !== 4'b0101) begin
      fails++;
      $display("FAIL timeout_status: got %b/%b exp 0101", st_s, st_l);
    end
    tests++;
    if (fidx_s !== 4'd2 || frd_s !== 5'd0 || fdat_s !== 32'd0) begin
      fails++;
      $display("FAIL timeout_info: got %h/%h/%h exp 2/0/0",
               fidx_s, frd_s, fdat_s);
    end
  endtask

  task automatic test_skip();
    run(5'd4);
    ev(e_rd[0], e_d[0]);
    ev(5'd5, 32'hAAAA0000);
    tests++;
    if (st_s !== 4'b0100 || fidx_s !== 4'd1 || frd_s !== 5'd5 ||
        fdat_s !== 32'hAAAA0000) begin
      fails++;
      $display("FAIL skip_strict: got %b %h/%h/%h exp 0100 1/05/aaaa0000",
               st_s, fidx_s, frd_s, fdat_s);
    end
    tests++;
    if (st_l !== 4'b1000) begin
      fails++;
      $display("FAIL skip_loose_run: got %b exp 1000", st_l);
    end
    for (int i = 1; i < 4; i++) ev(e_rd[i], e_d[i]);
    tests++;
    if (st_l !== 4'b0110) begin
      fails++;
      $display("FAIL skip_loose_pass: got %b exp 0110", st_l);
    end
    tests++;
    if (st_s !== 4'b0100 || fidx_s !== 4'd1) begin
      fails++;
      $display("FAIL skip_strict_hold: got %b idx %h exp 0100 idx 1",
               st_s, fidx_s);
    end
  endtask

  task automatic test_x0();
    run(5'd4);
    ev(5'd2, 32'h0);
    tests++;
    if (st_s !== 4'b0100 || fidx_s !== 4'd0 || frd_s !== 5'd2) begin
      fails++;
      $display("FAIL wrong_first: got %b %h/%h exp 0100 0/02",
               st_s, fidx_s, frd_s);
    end
    run(5'd0);
    tests++;
    if (st_s !== 4'b0110 || frd_s !== 5'd0) begin
      fails++;
      $display("FAIL zero_num_exp: got %b rd %h exp 0110 rd 0", st_s, frd_s);
    end
    run(5'd4);
    for (int i = 0; i < 4; i++) begin
      ev(e_rd[i], e_d[i]);
      if (i < 3) ev(5'd0, 32'h0);
    end
    tests++;
    if (st_s !== 4'b0110 || st_l !== 4'b0110) begin
      fails++;
      $display("FAIL x0_ignore: got %b/%b exp 0110", st_s, st_l);
    end
  endtask

  task automatic test_back_to_back();
    run(5'd4);
    ev(e_rd[0], e_d[0]);
    ld_en   = 1'b1;
    ld_idx  = 4'd3;
    ld_rd   = 5'd9;
    ld_data = 32'h0;
    num_exp = 5'd0;
    start   = 1'b1;
    step();
    ld_en   = 1'b0;
    start   = 1'b0;
    tests++;
    if (st_s !== 4'b1000) begin
      fails++;
      $display("FAIL start_in_run: got %b exp 1000", st_s);
    end
    for (int i = 1; i < 4; i++) ev(e_rd[i], e_d[i]);
    tests++;
    if (st_s !== 4'b0110 || st_l !== 4'b0110) begin
      fails++;
      $display("FAIL load_in_run: got %b/%b exp 0110", st_s, st_l);
    end
  endtask

  task automatic test_reset_mid();
    run(5'd4);
    ev(e_rd[0], e_d[0]);
    ev(e_rd[1], e_d[1]);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (st_s !== 4'b0000 || st_l !== 4'b0000 ||
        {fidx_s, frd_s, fdat_s} !== 41'd0) begin
      fails++;
      $display("FAIL reset_mid: got %b/%b %h exp 0000/0000 0", st_s, st_l,
               {fidx_s, frd_s, fdat_s});
    end
    #2;
    reset_n = 1'b1;
    step();
    run(5'd4);
    for (int i = 0; i < 4; i++) ev(e_rd[i], e_d[i]);
    tests++;
    if (st_s !== 4'b0110) begin
      fails++;
      $display("FAIL reset_restart: got %b exp 0110", st_s);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++) begin
      ld_en   = 1'b1;
      ld_idx  = 4'(i);
      ld_rd   = 5'(i + 1);
      ld_data = 32'hC0DE0000 + 32'(i);
      step();
    end
    ld_en = 1'b0;
    run(5'd31);
    for (int i = 0; i < 15; i++) ev(5'(i + 1), 32'hC0DE0000 + 32'(i));
    tests++;
    if (st_s !== 4'b1000) begin
      fails++;
      $display("FAIL clamp_early: got %b exp 1000", st_s);
    end
    ev(5'd16, 32'hC0DE000F);
    tests++;
    if (st_s !== 4'b0110) begin
      fails++;
      $display("FAIL clamp_pass: got %b exp 0110", st_s);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_skip();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
